// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared FSM state type and BCD digit width for the bin2bcd_seq converter
package bin2bcd_pkg;
    localparam int DIG_W = 4;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bin2bcd_dig_adj.sv
// bin2bcd_dig_adj: double-dabble digit correction, adds 3 to any digit of 5 or more
module bin2bcd_dig_adj
    import bin2bcd_pkg::*;
(
    input  logic [DIG_W-1:0] digit_in,
    output logic [DIG_W-1:0] digit_out
);
    assign digit_out = (digit_in >= DIG_W'(5)) ? digit_in + DIG_W'(3) : digit_in;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter; BIN2BCD_BLANK_EN adds a leading-zero blank mask
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        in_bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIG_W*DIGITS-1:0] out_bcd,
    output logic                    out_ovf,
    output logic [DIGITS-1:0]       out_blank
);
    localparam int CW    = $clog2(BIN_W + 1);
    localparam int BCD_W = DIG_W * DIGITS;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
    logic             ovf_q, ovf_d;
    logic [BCD_W-1:0] out_bcd_q, out_bcd_d;
    logic             out_ovf_q, out_ovf_d;
    logic             fin;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bin2bcd_dig_adj u_adj (
            .digit_in  (bcd_q[i*DIG_W +: DIG_W]),
            .digit_out (bcd_adj[i*DIG_W +: DIG_W])
        );
    end

    // all BIN_W shifts are done; results move to the output registers this edge
    assign fin       = (state_q == SHIFT) && (cnt_q == CW'(BIN_W));
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = out_bcd_q;
    assign out_ovf   = out_ovf_q;

    // next-state: load on accept, correct-then-shift while counting, publish on finish
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        out_bcd_d = out_bcd_q;
        out_ovf_d = out_ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                bin_d   = in_bin;
                bcd_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: if (fin) begin
                out_bcd_d = bcd_q;
                out_ovf_d = ovf_q;
                state_d   = DONE;
            end else begin
                {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                ovf_d          = ovf_q | bcd_adj[BCD_W-1];
                cnt_d          = cnt_q + CW'(1);
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset discards any conversion in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            out_bcd_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            out_bcd_q <= out_bcd_d;
            out_ovf_q <= out_ovf_d;
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_cur;
    logic              zero_run;

    // a digit is blank when it and every higher digit are zero; the ones digit always shows
    always_comb begin
        blank_cur = '0;
        zero_run  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run & (bcd_q[k*DIG_W +: DIG_W] == '0);
            blank_cur[k] = zero_run;
        end
        blank_d = fin ? blank_cur : blank_q;
    end

    // blank mask is captured on the same edge as out_bcd
    always_ff @(posedge clk or posedge reset) begin
        if (reset) blank_q <= '0;
        else       blank_q <= blank_d;
    end

    assign out_blank = blank_q;
`else
    assign out_blank = '0;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq at default, 4-digit and 8-bit/3-digit sizes
module tb_bin2bcd_seq;
    typedef struct packed {
        logic [39:0] bcd;
        logic        ovf;
        logic [9:0]  blank;
    } exp_t;

    logic clk, reset;
    int checks = 0, failures = 0, rx2 = 0;
    exp_t q0[$], q1[$], q2[$];

    logic        in_valid0, in_ready0, out_valid0, out_ready0, out_ovf0;
    logic [13:0] in_bin0;
    logic [19:0] out_bcd0;
    logic [4:0]  out_blank0;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_ovf1;
    logic [13:0] in_bin1;
    logic [15:0] out_bcd1;
    logic [3:0]  out_blank1;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, out_ovf2;
    logic [7:0]  in_bin2;
    logic [11:0] out_bcd2;
    logic [2:0]  out_blank2;

    bin2bcd_seq u_d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0), .in_bin(in_bin0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_bcd(out_bcd0), .out_ovf(out_ovf0),
        .out_blank(out_blank0)
    );

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .in_bin(in_bin1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_bcd(out_bcd1), .out_ovf(out_ovf1),
        .out_blank(out_blank1)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_bin(in_bin2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_bcd(out_bcd2), .out_ovf(out_ovf2),
        .out_blank(out_blank2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint p10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // decimal reference built from division, independent of the shift-add algorithm
    function automatic exp_t model(input longint v, input int digits);
        exp_t   e;
        longint m;
        e     = '0;
        m     = v % p10(digits);
        e.ovf = (v >= p10(digits));
        for (int i = 0; i < digits; i++) begin
            e.bcd[i*4 +: 4] = 4'((m / p10(i)) % 10);
`ifdef BIN2BCD_BLANK_EN
            if (i >= 1) e.blank[i] = (m < p10(i));
`endif
        end
        return e;
    endfunction

    task automatic send0(input longint v);
        int g = 0;
        @(negedge clk);
        in_valid0 = 1'b1;
        in_bin0   = 14'(v);
        while (!in_ready0 && g < 50) begin @(negedge clk); g++; end
        check("send0_ready", in_ready0, 1);
        q0.push_back(model(v, 5));
        @(posedge clk);
        #1 in_valid0 = 1'b0;
    endtask

    task automatic recv0(input int hold);
        int   n = 0;
        exp_t e;
        while (!out_valid0 && n < 100) begin @(posedge clk); #1; n++; end
        check("latency0", n, 15);
        check("q0_nonempty", q0.size() != 0, 1);
        e = (q0.size() != 0) ? q0.pop_front() : '0;
        check("bcd0", out_bcd0, e.bcd);
        check("ovf0", out_ovf0, e.ovf);
        check("blank0", out_blank0, e.blank);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_bcd0", out_bcd0, e.bcd);
            check("hold_ovf0", out_ovf0, e.ovf);
            check("hold_valid0", out_valid0, 1);
            check("hold_in_ready0", in_ready0, 0);
        end
        @(negedge clk);
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready0", in_ready0, 1);
        check("idle_out_valid0", out_valid0, 0);
        out_ready0 = 1'b0;
    endtask

    // entered at a negedge; leaves in_valid high so consecutive calls stream
    task automatic drive1(input longint v);
        int g = 0;
        in_valid1 = 1'b1;
        in_bin1   = 14'(v);
        while (!in_ready1 && g < 50) begin @(negedge clk); g++; end
        check("drive1_ready", in_ready1, 1);
        q1.push_back(model(v, 4));
        @(negedge clk);
    endtask

    task automatic drive2(input longint v);
        int g = 0;
        in_valid2 = 1'b1;
        in_bin2   = 8'(v);
        while (!in_ready2 && g < 50) begin @(negedge clk); g++; end
        check("drive2_ready", in_ready2, 1);
        q2.push_back(model(v, 3));
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid1) begin
            check("q1_nonempty", q1.size() != 0, 1);
            e = (q1.size() != 0) ? q1.pop_front() : '0;
            check("bcd1", out_bcd1, e.bcd);
            check("ovf1", out_ovf1, e.ovf);
            check("blank1", out_blank1, e.blank);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (out_valid2) begin
            check("q2_nonempty", q2.size() != 0, 1);
            e = (q2.size() != 0) ? q2.pop_front() : '0;
            check("bcd2", out_bcd2, e.bcd);
            check("ovf2", out_ovf2, e.ovf);
            check("blank2", out_blank2, e.blank);
            rx2++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int   g;
        logic seen;
        reset = 1'b1;
        in_valid0 = 1'b0; in_bin0 = '0; out_ready0 = 1'b0;
        in_valid1 = 1'b0; in_bin1 = '0; out_ready1 = 1'b1;
        in_valid2 = 1'b0; in_bin2 = '0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready0", in_ready0, 1);
        check("rst_out_valid0", out_valid0, 0);
        check("rst_bcd0", out_bcd0, 0);
        check("rst_ovf0", out_ovf0, 0);
        check("rst_blank0", out_blank0, 0);
        check("rst_in_ready1", in_ready1, 1);
        check("rst_in_ready2", in_ready2, 1);
        @(negedge clk);
        reset = 1'b0;

        send0(16383); recv0(0);
        send0(0);     recv0(0);
        send0(42);    recv0(0);
        send0(12345); recv0(10);
        send0(10000); recv0(0);
        send0(1);     recv0(0);

        send0(9999);
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid0", out_valid0, 0);
        check("midrst_in_ready0", in_ready0, 1);
        check("midrst_bcd0", out_bcd0, 0);
        check("midrst_ovf0", out_ovf0, 0);
        @(negedge clk);
        reset = 1'b0;
        q0.delete();
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid0;
        end
        check("midrst_no_valid0", seen, 0);
        check("midrst_in_ready_idle0", in_ready0, 1);
        send0(9999); recv0(0);

        @(negedge clk);
        drive1(12345);
        drive1(9999);
        drive1(10000);
        drive1(0);
        drive1(16383);
        in_valid1 = 1'b0;
        g = 0;
        while (q1.size() != 0 && g < 100) begin @(negedge clk); g++; end
        check("q1_drain", q1.size(), 0);

        for (int v = 0; v < 256; v++) drive2(v);
        in_valid2 = 1'b0;
        g = 0;
        while (q2.size() != 0 && g < 100) begin @(negedge clk); g++; end
        check("q2_drain", q2.size(), 0);
        check("rx2_count", rx2, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter BIN_W, default 14, binary input width; legal range 1..32.
REQ-002 Parameter DIGITS, default 5, number of BCD output digits; legal range 1..10.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port in_valid  in  1  binary word on in_bin is offered.
REQ-006 Port in_ready  out  1  block can accept a word this cycle.
REQ-007 Port in_bin  in  BIN_W  unsigned binary value.
REQ-008 Port out_valid  out  1  result on out_bcd/out_ovf/out_blank is valid.
REQ-009 Port out_ready  in  1  consumer accepts the result this cycle.
REQ-010 Port out_bcd  out  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0].
REQ-011 Port out_ovf  out  1  value exceeded 10^DIGITS-1; out_bcd then holds the value mod 10^DIGITS.
REQ-012 Port out_blank  out  DIGITS  leading-zero blank mask; bit i set means digit i is suppressed.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in SHIFT and DONE, in_ready SHALL be 0.
REQ-015 In IDLE with in_valid=1, the block SHALL load in_bin into the binary shift field, clear the BCD field, clear the overflow flag, clear the counter, and enter SHIFT.
REQ-016 Each SHIFT cycle SHALL first add 3 to every BCD digit >= 5, then shift the whole {bcd,bin} register left by 1 bit.
REQ-017 The bit shifted out of the top of the BCD field SHALL be ORed into a sticky overflow flag.
REQ-018 SHIFT SHALL last exactly BIN_W cycles, counted by a $clog2(BIN_W+1)-bit counter, then enter DONE.
REQ-019 Latency SHALL be: word accepted at edge N, out_valid=1 after edge N+BIN_W+1.
REQ-020 In DONE, out_valid SHALL be 1 and out_bcd/out_ovf/out_blank SHALL be held stable until out_ready=1.
REQ-021 DONE with out_ready=1 SHALL return to IDLE; the next word SHALL be accepted no earlier than the following cycle.
REQ-022 out_valid SHALL be 0 in IDLE and SHIFT; out_bcd SHALL be registered and change only on entry to DONE.
REQ-023 Input value 0 SHALL produce out_bcd=0, out_ovf=0, with full SHIFT latency (no early exit).
REQ-024 BCD arithmetic SHALL wrap per digit at 4 bits; no digit SHALL ever hold a value >9 at DONE.

Reset
REQ-025 reset=1 SHALL, at any time including mid-SHIFT, force IDLE, counter=0, shift register=0, out_bcd=0, out_ovf=0, out_blank=0, out_valid=0, in_ready=1 after release; any in-flight conversion is discarded.

Configuration
REQ-026 With BIN2BCD_BLANK_EN defined, out_blank[i] SHALL be 1 iff digit i and all higher digits are zero, for i>=1; out_blank[0] SHALL always be 0. The mask SHALL be registered with out_bcd.
REQ-027 Without BIN2BCD_BLANK_EN, out_blank SHALL be constant 0 and no blanking logic SHALL be synthesised.

Structure
REQ-028 Package bin2bcd_pkg SHALL hold the state enum type (IDLE/SHIFT/DONE) and the digit-width constant (4).
REQ-029 Per-digit correction (>=5 -> +3) SHALL be a combinational sub-module bin2bcd_dig_adj, instantiated DIGITS times via generate.

Verification
REQ-030 Defaults, in_bin=16383 -> out_bcd=20'h16383, out_ovf=0, out_valid exactly 15 cycles after acceptance.
REQ-031 Defaults with BLANK_EN, in_bin=0 -> out_bcd=20'h00000, out_blank=5'b11110; in_bin=42 -> out_blank=5'b11100.
REQ-032 DIGITS=4, in_bin=12345 -> out_ovf=1, out_bcd=16'h2345.
REQ-033 out_ready held 0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; on out_ready=1, IDLE next cycle.
REQ-034 reset pulsed at SHIFT cycle 7 of in_bin=9999 -> out_valid never asserts; next in_bin=9999 yields 20'h09999.
REQ-035 Back-to-back stream, BIN_W=8 DIGITS=3, inputs 0..255 with out_ready=1 -> every result matches reference decimal, out_ovf=0.
